fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage pipeline.
- Internally tracks destination register, write-enable and load flag for the instructions in stages p3, p4 and p5.
- Selects the youngest valid producer for each p2 source operand.
- Detects load-use hazards and raises a stall; counts stall cycles for performance monitoring.
- Sits between decode (p2) and the register-read operand muxes.

Parameters:
- DATA_W, 16, datapath width.
- ADDR_W, 3, register address width (2**ADDR_W registers; r0 is an ordinary register).
- NUM_SRC, 2, number of source operands checked per p2 instruction.
- LOAD_LAT, 1, stages after p3 before load data is valid. Legal values are 1 (valid at p4) and 2 (valid at p5); any other value fails elaboration.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  p2 instruction advances to p3 this edge (ignored while stall=1).
- issue_wr_en  in  1  p2 instruction writes a register.
- issue_wr_addr  in  ADDR_W  p2 destination register.
- issue_is_load  in  1  p2 instruction is a load.
- src_addr  in  NUM_SRC*ADDR_W  p2 source addresses; operand i is at [i*ADDR_W +: ADDR_W].
- src_used  in  NUM_SRC  operand i is actually read (e.g. 0 for immediates and op1=2'b10 forms).
- flush  in  1  kill the instruction entering p3 (branch taken).
- data_p3, data_p4, data_p5  in  DATA_W each  result values currently in p3, p4 and p5.
- fwd_data  out  NUM_SRC*DATA_W  forwarded value per operand.
- fwd_sel  out  NUM_SRC  1 = use fwd_data for operand i; 0 = use the register file.
- stall  out  1  hold p1/p2 this cycle.
- stall_cycles  out  16  saturating count of stalled cycles.

Behaviour:
- Tracking entries for p3, p4 and p5 each hold {v, addr, ld}, where v = write-enabled and valid.
- Reset (async): all v=0, stall_cycles=0. Outputs are therefore stall=0, fwd_sel=0 and fwd_data=0 while reset is high and after release.
- Each rising edge shifts p4 into p5 and p3 into p4; the old p5 entry retires.
- p3 loads {issue_valid & issue_wr_en, issue_wr_addr, issue_is_load}, except that it loads a bubble (v=0) if stall=1 or flush=1.
- Per operand i (combinational from tracking regs plus inputs), with priority p3 > p4 > p5 (youngest first). Match = src_used[i] & v & addr==src_addr[i].
  - Match in stage s that is a load not yet valid: hazard_i=1, fwd_sel[i]=0. "Not yet valid" means s < 3+LOAD_LAT.
  - Otherwise, first matching stage s: fwd_sel[i]=1, fwd_data[i]=data_ps.
  - No match: fwd_sel[i]=0, fwd_data[i]=0.
  - An older stage never overrides a younger match, even if the younger one is a hazard.
- stall = (OR of hazard_i) & ~flush. It is asserted in the same cycle it is detected (zero latency).
  - LOAD_LAT=1 gives 1 stall cycle for an adjacent dependent.
  - LOAD_LAT=2 gives 2 stall cycles when adjacent, and 1 when separated by one instruction.
- stall_cycles increments on each edge with stall=1 and saturates at 16'hFFFF.
- A src_used=0 operand never forwards and never stalls.
- flush and hazard in the same cycle: flush wins; no stall, no count, and a bubble enters p3.
- Reset mid-stall: stall drops immediately and the in-flight tracking is discarded.
- Both operands may match the same stage; each independently receives the same data.

Test Plan:
- ALU chain: issue writes r3 (non-load), then p2 reads r3 on operand 0 → fwd_sel=2'b01, fwd_data[0]=data_p3=16'h1234, stall=0.
- Priority: r5 written by p5 (16'hAAAA) and p3 (16'h5555), p2 reads r5 on both operands → fwd_sel=2'b11, both fwd_data=16'h5555.
- Load-use with LOAD_LAT=1: load r2 issued, p2 reads r2 → stall=1 for exactly 1 cycle, stall_cycles=1. Next cycle fwd_data=data_p4=16'hBEEF, stall=0.
- Load-use with LOAD_LAT=2: load r1, dependent immediately behind → stall high for 2 consecutive cycles, then data_p5 is forwarded and stall_cycles=2.
- Flush/unused: load r4 plus dependent with flush=1 → stall=0, counter unchanged. Separately, src_used=2'b00 with matching addresses → fwd_sel=0 and stall=0.
- Reset: assert reset asynchronously mid-stall → stall, fwd_sel and stall_cycles read 0 before the next edge. Then force 65536 stall cycles → counter holds 16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Operand-forwarding / hazard bus between decode (p2) and the register-read muxes.
// master = decode side driving the p2 instruction and stage data; slave = the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_SRC = 2
);
    logic                        issue_valid;
    logic                        issue_wr_en;
    logic [ADDR_W-1:0]           issue_wr_addr;
    logic                        issue_is_load;
    logic [NUM_SRC*ADDR_W-1:0]   src_addr;
    logic [NUM_SRC-1:0]          src_used;
    logic                        flush;
    logic [DATA_W-1:0]           data_p3;
    logic [DATA_W-1:0]           data_p4;
    logic [DATA_W-1:0]           data_p5;
    logic [NUM_SRC*DATA_W-1:0]   fwd_data;
    logic [NUM_SRC-1:0]          fwd_sel;
    logic                        stall;
    logic [15:0]                 stall_cycles;

    modport master (
        output issue_valid, issue_wr_en, issue_wr_addr, issue_is_load,
        output src_addr, src_used, flush, data_p3, data_p4, data_p5,
        input  fwd_data, fwd_sel, stall, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_wr_en, issue_wr_addr, issue_is_load,
        input  src_addr, src_used, flush, data_p3, data_p4, data_p5,
        output fwd_data, fwd_sel, stall, stall_cycles
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Tracks {valid-write, dest, is-load} for p3..p5, picks the youngest producer
// per p2 source operand, and stalls p1/p2 while a matching load is not ready.
module fwd_hazard_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input logic               clock,
    input logic               reset,
    fwd_hazard_unit_if.slave  bus
);
    if (LOAD_LAT != 1 && LOAD_LAT != 2) begin : g_bad_load_lat
        $error("fwd_hazard_unit: LOAD_LAT must be 1 or 2");
    end

    localparam int unsigned NUM_STAGES  = 3;
    localparam int unsigned LOAD_STAGES = LOAD_LAT;

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic              ld;
    } entry_t;

    // index 0 = p3 (youngest), 1 = p4, 2 = p5 (oldest)
    entry_t [NUM_STAGES-1:0]   trk;
    logic   [NUM_STAGES-1:0][DATA_W-1:0] stage_data;

    logic [NUM_SRC-1:0]        hazard;
    logic [NUM_SRC-1:0]        sel_c;
    logic [NUM_SRC*DATA_W-1:0] data_c;
    logic                      found;
    logic                      stall_c;
    logic [15:0]               stall_cnt;

    assign stage_data = {bus.data_p5, bus.data_p4, bus.data_p3};

    // Per-operand youngest-match search: a younger match blocks older stages even when it is a hazard.
    always_comb begin
        hazard = '0;
        sel_c  = '0;
        data_c = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            found = 1'b0;
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                if (!found && bus.src_used[i] && trk[s].v &&
                    trk[s].addr == bus.src_addr[i*ADDR_W +: ADDR_W]) begin
                    found = 1'b1;
                    if (trk[s].ld && s < LOAD_STAGES) begin
                        hazard[i] = 1'b1;
                    end else begin
                        sel_c[i]                    = 1'b1;
                        data_c[i*DATA_W +: DATA_W]  = stage_data[s];
                    end
                end
            end
        end
    end

    assign stall_c          = (|hazard) & ~bus.flush;
    assign bus.stall        = stall_c;
    assign bus.fwd_sel      = sel_c;
    assign bus.fwd_data     = data_c;
    assign bus.stall_cycles = stall_cnt;

    // Tracking shift register; a bubble enters p3 on stall or flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trk <= '0;
        end else begin
            trk[2] <= trk[1];
            trk[1] <= trk[0];
            if (stall_c || bus.flush) begin
                trk[0] <= '0;
            end else begin
                trk[0].v    <= bus.issue_valid & bus.issue_wr_en;
                trk[0].addr <= bus.issue_wr_addr;
                trk[0].ld   <= bus.issue_is_load;
            end
        end
    end

    // Saturating stall-cycle counter for performance monitoring.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_c && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two units (LOAD_LAT=1 and 2) share one stimulus stream and
// are checked against an in-bench model of the forwarding/stall rules.
module tb_fwd_hazard_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        iv, iwr, ild, fl;
    logic [2:0]  iaddr;
    logic [5:0]  saddr;
    logic [1:0]  sused;
    logic [15:0] d3, d4, d5;

    fwd_hazard_unit_if #(.DATA_W(16), .ADDR_W(3), .NUM_SRC(2)) if1 ();
    fwd_hazard_unit_if #(.DATA_W(16), .ADDR_W(3), .NUM_SRC(2)) if2 ();

    assign if1.issue_valid = iv;    assign if2.issue_valid = iv;
    assign if1.issue_wr_en = iwr;   assign if2.issue_wr_en = iwr;
    assign if1.issue_wr_addr = iaddr; assign if2.issue_wr_addr = iaddr;
    assign if1.issue_is_load = ild; assign if2.issue_is_load = ild;
    assign if1.src_addr = saddr;    assign if2.src_addr = saddr;
    assign if1.src_used = sused;    assign if2.src_used = sused;
    assign if1.flush = fl;          assign if2.flush = fl;
    assign if1.data_p3 = d3;        assign if2.data_p3 = d3;
    assign if1.data_p4 = d4;        assign if2.data_p4 = d4;
    assign if1.data_p5 = d5;        assign if2.data_p5 = d5;

    fwd_hazard_unit #(.DATA_W(16), .ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .bus(if1)
    );
    fwd_hazard_unit #(.DATA_W(16), .ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(2)) u_dut2 (
        .clock(clock), .reset(reset), .bus(if2)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          d;
        logic [1:0]  sel;
        logic [31:0] fd;
        logic        st;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    event sample;

    // Reference model: list of in-flight writers, youngest first, with the
    // number of stages a load needs before its data can be forwarded.
    logic       m_v [2][3];
    logic [2:0] m_a [2][3];
    logic       m_l [2][3];
    int         m_cnt [2];
    logic       m_st [2];
    int         lat [2] = '{1, 2};
    string      tname = "reset";

    function automatic void model_clear(input int d);
        for (int k = 0; k < 3; k++) begin
            m_v[d][k] = 1'b0; m_a[d][k] = 3'd0; m_l[d][k] = 1'b0;
        end
        m_cnt[d] = 0;
    endfunction

    function automatic void eval(input int d, output logic [1:0] sel,
                                 output logic [31:0] fd, output logic st);
        logic [15:0] dat [3];
        logic [2:0]  src;
        logic        hz;
        int          age;
        dat[0] = d3; dat[1] = d4; dat[2] = d5;
        sel = 2'b00; fd = '0; hz = 1'b0;
        for (int op = 0; op < 2; op++) begin
            src = saddr[op*3 +: 3];
            age = -1;
            if (sused[op]) begin
                for (int k = 2; k >= 0; k--)
                    if (m_v[d][k] && m_a[d][k] == src) age = k;
            end
            if (age >= 0) begin
                if (m_l[d][age] && age < lat[d]) hz = 1'b1;
                else begin
                    sel[op] = 1'b1;
                    fd[op*16 +: 16] = dat[age];
                end
            end
        end
        st = hz & ~fl;
    endfunction

    function automatic void model_edge(input int d);
        if (reset) begin
            model_clear(d);
        end else begin
            if (m_st[d]) m_cnt[d]++;
            for (int k = 2; k > 0; k--) begin
                m_v[d][k] = m_v[d][k-1]; m_a[d][k] = m_a[d][k-1]; m_l[d][k] = m_l[d][k-1];
            end
            if (m_st[d] || fl) begin
                m_v[d][0] = 1'b0; m_a[d][0] = 3'd0; m_l[d][0] = 1'b0;
            end else begin
                m_v[d][0] = iv & iwr; m_a[d][0] = iaddr; m_l[d][0] = ild;
            end
        end
    endfunction

    task automatic push_expect();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            eval(d, e.sel, e.fd, e.st);
            m_st[d] = reset ? 1'b0 : e.st;
            if (reset) begin
                e.sel = '0; e.fd = '0; e.st = 1'b0;
            end
            e.d = d;
            e.cnt = (m_cnt[d] > 65535) ? 16'hFFFF : 16'(m_cnt[d]);
            e.name = tname;
            exp_q.push_back(e);
        end
        -> sample;
    endtask

    // Inputs change just after the active edge; outputs are sampled 1ns later.
    task automatic apply(input logic v, input logic w, input logic [2:0] a, input logic l,
                         input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] u, input logic f);
        iv = v; iwr = w; iaddr = a; ild = l;
        saddr = {s1, s0}; sused = u; fl = f;
        #1;
        push_expect();
    endtask

    task automatic advance();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic step(input logic v, input logic w, input logic [2:0] a, input logic l,
                        input logic [2:0] s0, input logic [2:0] s1,
                        input logic [1:0] u, input logic f);
        apply(v, w, a, l, s0, s1, u, f);
        advance();
    endtask

    task automatic rnd_data();
        d3 = 16'($urandom); d4 = 16'($urandom); d5 = 16'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    // Monitor: pops one expectation per unit whenever a sample is presented.
    initial begin
        exp_t e;
        logic [1:0]  a_sel;
        logic [31:0] a_fd;
        logic        a_st;
        logic [15:0] a_cnt;
        forever begin
            @(sample);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.d == 0) begin
                    a_sel = if1.fwd_sel; a_fd = if1.fwd_data; a_st = if1.stall; a_cnt = if1.stall_cycles;
                end else begin
                    a_sel = if2.fwd_sel; a_fd = if2.fwd_data; a_st = if2.stall; a_cnt = if2.stall_cycles;
                end
                checks += 4;
                if (a_sel !== e.sel) begin
                    errors++;
                    $display("FAIL %s lat%0d fwd_sel: got %b want %b @%0t", e.name, e.d + 1, a_sel, e.sel, $time);
                end
                if (a_fd !== e.fd) begin
                    errors++;
                    $display("FAIL %s lat%0d fwd_data: got %h want %h @%0t", e.name, e.d + 1, a_fd, e.fd, $time);
                end
                if (a_st !== e.st) begin
                    errors++;
                    $display("FAIL %s lat%0d stall: got %b want %b @%0t", e.name, e.d + 1, a_st, e.st, $time);
                end
                if (a_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s lat%0d stall_cycles: got %h want %h @%0t", e.name, e.d + 1, a_cnt, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        #(1_200_000 * 10);
        errors++;
        $display("FAIL watchdog: got timeout want finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_clear(0); model_clear(1);
        m_st[0] = 1'b0; m_st[1] = 1'b0;
        d3 = 16'h0; d4 = 16'h0; d5 = 16'h0;
        @(negedge clock);

        // reset held: outputs zero even with a matching producer pattern
        tname = "reset";
        step(1, 1, 3'd2, 1, 3'd2, 3'd2, 2'b11, 0);
        step(1, 1, 3'd2, 1, 3'd2, 3'd2, 2'b11, 0);
        reset = 1'b0;

        tname = "alu_chain";
        step(1, 1, 3'd3, 0, 3'd0, 3'd0, 2'b00, 0);
        d3 = 16'h1234;
        step(0, 0, 3'd0, 0, 3'd3, 3'd0, 2'b01, 0);
        drain();

        tname = "priority";
        step(1, 1, 3'd5, 0, 3'd0, 3'd0, 2'b00, 0);
        step(1, 1, 3'd6, 0, 3'd0, 3'd0, 2'b00, 0);
        step(1, 1, 3'd5, 0, 3'd0, 3'd0, 2'b00, 0);
        d3 = 16'h5555; d4 = 16'h0F0F; d5 = 16'hAAAA;
        step(0, 0, 3'd0, 0, 3'd5, 3'd5, 2'b11, 0);
        drain();

        tname = "load_use";
        step(1, 1, 3'd2, 1, 3'd0, 3'd0, 2'b00, 0);
        d3 = 16'h1111; d4 = 16'hBEEF; d5 = 16'hCAFE;
        for (int i = 0; i < 3; i++) step(1, 0, 3'd0, 0, 3'd2, 3'd7, 2'b01, 0);
        drain();

        tname = "load_gap";
        step(1, 1, 3'd1, 1, 3'd0, 3'd0, 2'b00, 0);
        step(1, 1, 3'd6, 0, 3'd0, 3'd0, 2'b00, 0);
        d4 = 16'h4444; d5 = 16'h5A5A;
        for (int i = 0; i < 2; i++) step(1, 0, 3'd0, 0, 3'd7, 3'd1, 2'b10, 0);
        drain();

        tname = "flush";
        step(1, 1, 3'd4, 1, 3'd0, 3'd0, 2'b00, 0);
        step(1, 1, 3'd4, 0, 3'd4, 3'd4, 2'b11, 1);
        step(0, 0, 3'd0, 0, 3'd4, 3'd4, 2'b00, 0);
        drain();

        tname = "unused";
        step(1, 1, 3'd4, 1, 3'd0, 3'd0, 2'b00, 0);
        step(0, 0, 3'd0, 0, 3'd4, 3'd4, 2'b00, 0);
        drain();

        tname = "random";
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            step(1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                 2'($urandom), ($urandom_range(0, 9) == 0));
        end
        drain();

        tname = "reset_mid_stall";
        step(1, 1, 3'd1, 1, 3'd0, 3'd0, 2'b00, 0);
        apply(0, 0, 3'd0, 0, 3'd1, 3'd1, 2'b11, 0);
        #2;
        reset = 1'b1;
        model_clear(0); model_clear(1);
        #1;
        push_expect();
        advance();
        reset = 1'b0;

        // back-to-back dependent loads; LOAD_LAT=2 stalls two of every three cycles
        tname = "saturate";
        for (int i = 0; i < 99_000 && m_cnt[1] < 65540; i++) begin
            d5 = 16'(i);
            step(1, 1, 3'd1, 1, 3'd1, 3'd0, 2'b01, 0);
        end
        checks++;
        if (m_cnt[1] < 65540) begin
            errors++;
            $display("FAIL saturate_budget: got %0d stall cycles want >= 65540", m_cnt[1]);
        end
        tname = "saturate_hold";
        step(0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0);

        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
